// File: rtl/display_scan_ctrl.sv
// Multiplexed 7-segment scan controller: internal digit timing, frame-synchronous
// number load, PWM brightness, per-digit blink and leading-zero blanking.
module display_scan_ctrl #(
    parameter int NRO_DIGITOS  = 4,
    parameter int PRESCALER    = 25000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [5*NRO_DIGITOS-1:0]   in_num,
    input  logic                       in_valid,
    output logic                       out_ready,
    input  logic [2:0]                 brightness,
    input  logic [NRO_DIGITOS-1:0]     blink_mask,
    input  logic                       lz_blank,
    output logic [5:0]                 out_digit_select,
    output logic [4:0]                 out_digit_number,
    output logic                       out_frame_start
);

    localparam int PW     = $clog2(PRESCALER);
    localparam int IW     = (NRO_DIGITOS > 1) ? $clog2(NRO_DIGITOS) : 1;
    localparam int FW     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int TW     = PW + 3;
    localparam int SLOT_W = PRESCALER / 8;

    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALER - 1);
    localparam logic [IW-1:0] IDX_MAX   = IW'(NRO_DIGITOS - 1);
    localparam logic [FW-1:0] FRAME_MAX = FW'(BLINK_FRAMES - 1);

    logic [PW-1:0] presc_cnt;
    logic [IW-1:0] idx;
    logic [FW-1:0] frame_cnt;
    logic          blink_phase;
    logic          first_q;
    logic          shadow_full;
    logic [4:0]    shadow [NRO_DIGITOS];
    logic [4:0]    disp   [NRO_DIGITOS];

    logic                   slot_end;
    logic                   frame_end;
    logic                   accept;
    logic [TW-1:0]          pwm_thr;
    logic [NRO_DIGITOS-1:0] zero_from;
    logic                   run;
    logic                   blank;
    logic [5:0]             sel_p0;
    logic [4:0]             num_p0;

    assign slot_end  = (presc_cnt == PRESC_MAX);
    assign frame_end = slot_end && (idx == IDX_MAX);
    assign accept    = in_valid && !shadow_full;
    assign out_ready = !shadow_full;
    assign pwm_thr   = TW'(brightness) * TW'(SLOT_W);

    // zero_from[i]: digits i..top of the display register are all 0 with no dp
    always_comb begin
        run       = 1'b1;
        zero_from = '0;
        for (int i = NRO_DIGITOS - 1; i >= 0; i--) begin
            run          = run && (disp[i] == 5'd0);
            zero_from[i] = run;
        end
    end

    // p0: blanking decision and pin values for the current idx/presc_cnt
    always_comb begin
        blank = (brightness == 3'd0)
             || (brightness != 3'd7 && TW'(presc_cnt) >= pwm_thr)
             || (blink_mask[idx] && blink_phase)
             || (lz_blank && idx != '0 && zero_from[idx]);
        sel_p0 = blank ? 6'h3F : ~(6'd1 << idx);
        num_p0 = blank ? 5'd0  : disp[idx];
    end

    // shadow data needs no reset: it is only observable through shadow_full
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < NRO_DIGITOS; i++) shadow[i] <= in_num[5*i +: 5];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_cnt        <= '0;
            idx              <= '0;
            frame_cnt        <= '0;
            blink_phase      <= 1'b0;
            first_q          <= 1'b1;
            shadow_full      <= 1'b0;
            for (int i = 0; i < NRO_DIGITOS; i++) disp[i] <= 5'd0;
            out_digit_select <= 6'h3F;
            out_digit_number <= 5'd0;
            out_frame_start  <= 1'b0;
        end else begin
            presc_cnt <= slot_end ? '0 : presc_cnt + PW'(1);
            if (slot_end) idx <= (idx == IDX_MAX) ? '0 : idx + IW'(1);

            if (frame_end) begin
                if (frame_cnt == FRAME_MAX) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + FW'(1);
                end
            end

            // accept and transfer are mutually exclusive via shadow_full
            if (accept) begin
                shadow_full <= 1'b1;
            end else if (frame_end && shadow_full) begin
                disp        <= shadow;
                shadow_full <= 1'b0;
            end

            // p1: registered pins
            out_digit_select <= sel_p0;
            out_digit_number <= num_p0;
            out_frame_start  <= frame_end | first_q;
            first_q          <= 1'b0;
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl: a cycle-count based model pushes the
// expected pin state at every rising edge; scenario tasks pop and compare it.
module tb_display_scan_ctrl;

    localparam int N  = 4;
    localparam int P  = 8;
    localparam int BF = 2;

    typedef struct packed {
        logic [5:0] sel;
        logic [4:0] num;
        logic       fs;
        logic       rdy;
    } obs_t;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [5*N-1:0] in_num = '0;
    logic           in_valid = 1'b0;
    logic           out_ready;
    logic [2:0]     brightness = 3'd7;
    logic [N-1:0]   blink_mask = '0;
    logic           lz_blank = 1'b0;
    logic [5:0]     out_digit_select;
    logic [4:0]     out_digit_number;
    logic           out_frame_start;

    int checks = 0;
    int errors = 0;

    obs_t q[$];

    // model state: time since reset release drives all scan timing
    int             t = 0;
    logic           m_first = 1'b0;
    logic           m_full = 1'b0;
    logic [5*N-1:0] m_shadow = '0;
    logic [4:0]     m_disp [N];

    display_scan_ctrl #(.NRO_DIGITOS(N), .PRESCALER(P), .BLINK_FRAMES(BF)) dut (
        .clk(clk), .reset(reset), .in_num(in_num), .in_valid(in_valid),
        .out_ready(out_ready), .brightness(brightness), .blink_mask(blink_mask),
        .lz_blank(lz_blank), .out_digit_select(out_digit_select),
        .out_digit_number(out_digit_number), .out_frame_start(out_frame_start)
    );

    always #5 clk = ~clk;

    function automatic obs_t model_next();
        obs_t e;
        int   presc, idx;
        bit   fe, blank, lz, nf;
        if (reset) return '{6'h3F, 5'd0, 1'b0, 1'b1};
        presc = t % P;
        idx   = (t / P) % N;
        fe    = (t % (P * N)) == P * N - 1;
        blank = (brightness == 0) || (brightness < 7 && presc >= int'(brightness) * (P / 8));
        if (blink_mask[idx] && ((t / (P * N)) / BF) % 2 == 1) blank = 1;
        lz = 1;
        for (int j = idx; j < N; j++) if (m_disp[j] != 5'd0) lz = 0;
        if (lz_blank && idx > 0 && lz) blank = 1;
        e.sel = 6'h3F;
        e.num = 5'd0;
        if (!blank) begin
            e.sel[idx] = 1'b0;
            e.num      = m_disp[idx];
        end
        e.fs  = fe || m_first;
        nf    = m_full ? !fe : in_valid;
        e.rdy = !nf;
        return e;
    endfunction

    always @(posedge clk) begin
        q.push_back(model_next());
        if (reset) begin
            t       <= 0;
            m_first <= 1'b1;
            m_full  <= 1'b0;
            for (int j = 0; j < N; j++) m_disp[j] <= 5'd0;
        end else begin
            t       <= t + 1;
            m_first <= 1'b0;
            if (m_full) begin
                if ((t % (P * N)) == P * N - 1) begin
                    for (int j = 0; j < N; j++) m_disp[j] <= m_shadow[5*j +: 5];
                    m_full <= 1'b0;
                end
            end else if (in_valid) begin
                m_shadow <= in_num;
                m_full   <= 1'b1;
            end
        end
    end

    task automatic test_reset();
        obs_t e, o;
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            e = q.pop_front();
            o = {out_digit_select, out_digit_number, out_frame_start, out_ready};
            checks++;
            if (o !== e) begin errors++; $display("FAIL reset got %b want %b", o, e); end
        end
        reset = 1'b0;
        repeat (2) begin
            @(negedge clk);
            e = q.pop_front();
            o = {out_digit_select, out_digit_number, out_frame_start, out_ready};
            checks++;
            if (o !== e) begin errors++; $display("FAIL release got %b want %b", o, e); end
        end
    endtask

    task automatic test_scan();
        obs_t e, o;
        in_num   = {5'h08, 5'h06, 5'h04, 5'h02};
        in_valid = 1'b1;
        for (int i = 0; i < 3 * P * N; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            e = q.pop_front();
            o = {out_digit_select, out_digit_number, out_frame_start, out_ready};
            checks++;
            if (o !== e) begin errors++; $display("FAIL scan cyc%0d got %b want %b", i, o, e); end
        end
    endtask

    task automatic test_handshake();
        obs_t e, o;
        for (int i = 0; i < 110; i++) begin
            @(negedge clk);
            e = q.pop_front();
            o = {out_digit_select, out_digit_number, out_frame_start, out_ready};
            checks++;
            if (o !== e) begin errors++; $display("FAIL handshake cyc%0d got %b want %b", i, o, e); end
            in_valid = (i >= 9 && i <= 11);
            in_num   = (i == 9) ? {4{5'h12}} : {4{5'h0E}};
        end
        in_valid = 1'b0;
    endtask

    task automatic test_brightness();
        obs_t e, o;
        for (int i = 0; i < 4 * P * N; i++) begin
            brightness = (i < 2 * P * N) ? 3'd2 : 3'd0;
            @(negedge clk);
            e = q.pop_front();
            o = {out_digit_select, out_digit_number, out_frame_start, out_ready};
            checks++;
            if (o !== e) begin errors++; $display("FAIL brightness cyc%0d got %b want %b", i, o, e); end
        end
        brightness = 3'd7;
    endtask

    task automatic test_leading_zero();
        obs_t           e, o;
        logic [5*N-1:0] pats [3];
        pats[0]  = {5'h00, 5'h00, 5'h00, 5'h0A};
        pats[1]  = {5'h00, 5'h01, 5'h00, 5'h0A};
        pats[2]  = '0;
        lz_blank = 1'b1;
        for (int p = 0; p < 3; p++) begin
            in_num   = pats[p];
            in_valid = 1'b1;
            for (int i = 0; i < 80; i++) begin
                @(negedge clk);
                in_valid = 1'b0;
                e = q.pop_front();
                o = {out_digit_select, out_digit_number, out_frame_start, out_ready};
                checks++;
                if (o !== e) begin errors++; $display("FAIL lz p%0d cyc%0d got %b want %b", p, i, o, e); end
            end
        end
        lz_blank = 1'b0;
    endtask

    task automatic test_blink();
        obs_t e, o;
        in_num     = {5'h1E, 5'h06, 5'h04, 5'h02};
        in_valid   = 1'b1;
        blink_mask = 4'b0010;
        for (int i = 0; i < 9 * P * N; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            e = q.pop_front();
            o = {out_digit_select, out_digit_number, out_frame_start, out_ready};
            checks++;
            if (o !== e) begin errors++; $display("FAIL blink cyc%0d got %b want %b", i, o, e); end
        end
        blink_mask = '0;
    endtask

    task automatic test_reset_mid();
        obs_t e, o;
        in_num   = {4{5'h12}};
        in_valid = 1'b1;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            e = q.pop_front();
            o = {out_digit_select, out_digit_number, out_frame_start, out_ready};
            checks++;
            if (o !== e) begin errors++; $display("FAIL reset_mid cyc%0d got %b want %b", i, o, e); end
            reset = (i == 4);
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_handshake();
        test_brightness();
        test_leading_zero();
        test_blink();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
